// File: rtl/data_cache_pkg.sv
// Shared constants, FSM encoding and lane helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int unsigned ADDR_BITS     = 32;
  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned BLOCK_BYTES   = 16;
  localparam int unsigned BLOCK_BITS    = BLOCK_BYTES * 8;
  localparam int unsigned OFF_BITS      = 4;
  localparam int unsigned BLK_ADDR_BITS = ADDR_BITS - OFF_BITS;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_UPDATE    = 2'd3
  } state_t;

  // First byte lane of an access; misaligned low offset bits are dropped.
  function automatic logic [OFF_BITS-1:0] lane_base(input logic [1:0] size,
                                                    input logic [OFF_BITS-1:0] offset);
    case (size)
      SZ_HALF: return offset & 4'b1110;
      SZ_WORD: return offset & 4'b1100;
      default: return offset;
    endcase
  endfunction

  // Byte lanes touched within the 32-bit word, right-aligned.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU data-memory port: the CPU is master, the cache is slave.
interface data_cache_if;
  import data_cache_pkg::*;

  logic [1:0]           READ;
  logic [1:0]           WRITE;
  logic [ADDR_BITS-1:0] ADDR;
  logic [WORD_BITS-1:0] DATA_IN;
  logic [WORD_BITS-1:0] DATA_OUT;
  logic                 BUSYWAIT;

  modport master (
    output READ, WRITE, ADDR, DATA_IN,
    input  DATA_OUT, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDR, DATA_IN,
    output DATA_OUT, BUSYWAIT
  );
endinterface

// File: rtl/dcache_array.sv
// Data/tag/valid/dirty storage for the direct-mapped cache, with byte-enable merge.
module dcache_array
  import data_cache_pkg::*;
#(
  parameter int unsigned IDX_BITS = 3,
  parameter int unsigned TAG_BITS = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_BITS-1:0]   idx,
  input  logic                  wr_en,
  input  logic [BLOCK_BYTES-1:0] wr_be,
  input  logic [BLOCK_BITS-1:0] wr_data,
  input  logic                  fill_en,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  logic [BLOCK_BITS-1:0] fill_data,
  output logic [TAG_BITS-1:0]   line_tag,
  output logic                  line_valid,
  output logic                  line_dirty,
  output logic [BLOCK_BITS-1:0] line_data
);

  localparam int unsigned SETS = 1 << IDX_BITS;

  logic [BLOCK_BITS-1:0] data_mem [SETS];
  logic [TAG_BITS-1:0]   tag_mem  [SETS];
  logic [SETS-1:0]       valid_bits;
  logic [SETS-1:0]       dirty_bits;

  // Status bits: cleared on reset, set by refill or CPU store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_en) begin
      valid_bits[idx] <= 1'b1;
      dirty_bits[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_bits[idx] <= 1'b1;
    end
  end

  // Block and tag storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && fill_en) begin
      data_mem[idx] <= fill_data;
      tag_mem[idx]  <= fill_tag;
    end else if (rst_n && wr_en) begin
      for (int b = 0; b < int'(BLOCK_BYTES); b++) begin
        if (wr_be[b]) data_mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign line_tag   = tag_mem[idx];
  assign line_valid = valid_bits[idx];
  assign line_dirty = dirty_bits[idx];
  assign line_data  = data_mem[idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with zero-wait hits.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned IDX_BITS = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  data_cache_if.slave              cpu,
  output logic                     MEM_READ,
  output logic                     MEM_WRITE,
  output logic [BLK_ADDR_BITS-1:0] MEM_ADDR,
  output logic [BLOCK_BITS-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_BITS-1:0]    MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  localparam int unsigned TAG_BITS = BLK_ADDR_BITS - IDX_BITS;

  state_t state, state_next;

  logic [IDX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]    tag;
  logic [OFF_BITS-1:0]    offset;
  logic                   is_write;
  logic                   req;
  logic [1:0]             size;
  logic [OFF_BITS-1:0]    base;
  logic [3:0]             lanes;
  logic [BLOCK_BYTES-1:0] wr_be;
  logic [BLOCK_BITS-1:0]  wr_data;
  logic [WORD_BITS-1:0]   rd_word;
  logic [WORD_BITS-1:0]   rd_mask;

  logic [TAG_BITS-1:0]    line_tag;
  logic                   line_valid;
  logic                   line_dirty;
  logic [BLOCK_BITS-1:0]  line_data;
  logic                   hit;

  logic                   busy;
  logic                   mem_rd;
  logic                   mem_wr;
  logic [BLK_ADDR_BITS-1:0] mem_addr;
  logic                   array_wr;
  logic                   fill_en;

  // Address split and lane placement of the current request.
  assign idx      = cpu.ADDR[IDX_BITS+OFF_BITS-1:OFF_BITS];
  assign tag      = cpu.ADDR[ADDR_BITS-1:IDX_BITS+OFF_BITS];
  assign offset   = cpu.ADDR[OFF_BITS-1:0];
  assign is_write = |cpu.WRITE;
  assign req      = is_write | (|cpu.READ);
  assign size     = is_write ? cpu.WRITE : cpu.READ;
  assign base     = lane_base(size, offset);
  assign lanes    = size_mask(size);
  assign wr_be    = BLOCK_BYTES'(lanes) << base;
  assign wr_data  = BLOCK_BITS'(cpu.DATA_IN) << {base, 3'b000};
  assign rd_word  = WORD_BITS'(line_data >> {base, 3'b000});
  assign rd_mask  = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign hit      = line_valid && (line_tag == tag);

  dcache_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk        (CLK),
    .rst_n      (RESET),
    .idx        (idx),
    .wr_en      (array_wr),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .fill_en    (fill_en),
    .fill_tag   (tag),
    .fill_data  (MEM_READDATA),
    .line_tag   (line_tag),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_data  (line_data)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state, memory handshake and array write controls.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = cpu.ADDR[ADDR_BITS-1:OFF_BITS];
    array_wr   = 1'b0;
    fill_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            array_wr = is_write;
          end else begin
            busy       = 1'b1;
            state_next = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        busy     = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = {line_tag, idx};
        if (!MEM_BUSYWAIT) state_next = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (!MEM_BUSYWAIT) state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        busy       = 1'b1;
        fill_en    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign cpu.BUSYWAIT  = busy;
  assign cpu.DATA_OUT  = rd_word & rd_mask;
  assign MEM_READ      = mem_rd;
  assign MEM_WRITE     = mem_wr;
  assign MEM_ADDR      = mem_addr;
  assign MEM_WRITEDATA = line_data;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: byte-level reference model plus load scoreboard.
module tb_data_cache;
  import data_cache_pkg::*;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         mem_read, mem_write, mem_busywait;
  logic [27:0]  mem_addr;
  logic [127:0] mem_writedata, mem_readdata;

  data_cache_if cpu ();

  data_cache #(.IDX_BITS(3)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .cpu           (cpu),
    .MEM_READ      (mem_read),
    .MEM_WRITE     (mem_write),
    .MEM_ADDR      (mem_addr),
    .MEM_WRITEDATA (mem_writedata),
    .MEM_READDATA  (mem_readdata),
    .MEM_BUSYWAIT  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0]  exp_q [$];
  logic [127:0] mem_blk [int];
  logic [127:0] ref_blk [int];
  int mem_lat = 0;
  int mm_kind, mm_act = 0, mm_cnt = 0;
  bit overlap_seen = 1'b0;

  function automatic logic [127:0] init_block(input int b);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) v[32*w +: 32] = (32'(w + 1) << 28) ^ (32'(b) * 32'h0001_0103);
    return v;
  endfunction

  function automatic logic [127:0] mem_get(input int b);
    return mem_blk.exists(b) ? mem_blk[b] : init_block(b);
  endfunction

  function automatic logic [127:0] ref_get(input int b);
    return ref_blk.exists(b) ? ref_blk[b] : mem_get(b);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : (sz == 2'd3) ? 4 : 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz);
    logic [127:0] blk;
    logic [31:0] r;
    int off, n;
    blk = ref_get(int'(a[31:4]));
    n   = nbytes(sz);
    off = int'(a[3:0]);
    if (n > 1) off = off - (off % n);
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = blk[8*(off+i) +: 8];
    return r;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [127:0] blk;
    int off, n;
    blk = ref_get(int'(a[31:4]));
    n   = nbytes(sz);
    off = int'(a[3:0]);
    if (n > 1) off = off - (off % n);
    for (int i = 0; i < n; i++) blk[8*(off+i) +: 8] = d[8*i +: 8];
    ref_blk[int'(a[31:4])] = blk;
  endtask

  // Main-memory responder: holds MEM_BUSYWAIT for mem_lat cycles per transfer.
  always @(negedge CLK) begin
    if (mem_read && mem_write) overlap_seen = 1'b1;
    mm_kind = mem_write ? 2 : (mem_read ? 1 : 0);
    if (mm_kind == 0) begin
      mm_act = 0;
      mem_busywait = 1'b0;
    end else if (mm_kind != mm_act) begin
      mm_act = mm_kind;
      mm_cnt = mem_lat;
      mem_busywait = (mm_cnt != 0);
      if (mm_kind == 1) mem_readdata = mem_get(int'(mem_addr));
      if (mm_kind == 2 && mm_cnt == 0) mem_blk[int'(mem_addr)] = mem_writedata;
    end else if (mm_cnt > 0) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        mem_busywait = 1'b0;
        if (mm_kind == 2) mem_blk[int'(mem_addr)] = mem_writedata;
      end
    end
  end

  // Drives one request and waits (bounded) for BUSYWAIT to drop.
  task automatic cpu_access(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] dout, output int waits,
                            output bit timeout);
    @(negedge CLK);
    cpu.READ = rd; cpu.WRITE = wr; cpu.ADDR = a; cpu.DATA_IN = d;
    waits = 0; timeout = 1'b0;
    #1;
    while (cpu.BUSYWAIT !== 1'b0 && !timeout) begin
      @(negedge CLK); #1;
      waits++;
      if (waits > 200) timeout = 1'b1;
    end
    dout = cpu.DATA_OUT;
  endtask

  task automatic wait_idle(output int waits);
    waits = 0;
    while (cpu.BUSYWAIT !== 1'b0 && waits < 200) begin
      @(negedge CLK); #1;
      waits++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    cpu.READ = SZ_NONE; cpu.WRITE = SZ_NONE; cpu.ADDR = '0; cpu.DATA_IN = '0;
    mem_busywait = 1'b0; mem_readdata = '0;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (cpu.BUSYWAIT !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL reset_outputs: busywait=%b mem_read=%b mem_write=%b, want 0 0 0",
               cpu.BUSYWAIT, mem_read, mem_write);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b1;
    ref_blk.delete();
  endtask

  task automatic test_read_miss();
    logic [31:0] exp;
    int w;
    mem_lat = 2;
    exp_q.push_back(model_load(32'h40, SZ_WORD));
    @(negedge CLK);
    cpu.READ = SZ_WORD; cpu.WRITE = SZ_NONE; cpu.ADDR = 32'h40; cpu.DATA_IN = '0;
    #1;
    n_checks++;
    if (cpu.BUSYWAIT !== 1'b1) $display("FAIL miss_busy_same_cycle: got %b want 1", cpu.BUSYWAIT);
    else n_pass++;
    @(negedge CLK); #1;
    n_checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h000_0004)
      $display("FAIL alloc_request: mem_read=%b mem_write=%b mem_addr=%h, want 1 0 0000004",
               mem_read, mem_write, mem_addr);
    else n_pass++;
    wait_idle(w);
    exp = exp_q.pop_front();
    n_checks++;
    if (cpu.BUSYWAIT !== 1'b0 || cpu.DATA_OUT !== exp || exp !== init_block(4)[31:0])
      $display("FAIL fill_word0: busy=%b data=%h, want 0 %h", cpu.BUSYWAIT, cpu.DATA_OUT, exp);
    else n_pass++;
  endtask

  task automatic test_write_hit();
    logic [31:0] d, exp;
    logic [31:0] addrs [4] = '{32'h40, 32'h42, 32'h43, 32'h41};
    logic [1:0]  sizes [4] = '{SZ_WORD, SZ_HALF, SZ_BYTE, SZ_BYTE};
    int w;
    bit to;
    model_store(32'h43, SZ_BYTE, 32'h0000_00AB);
    cpu_access(SZ_NONE, SZ_BYTE, 32'h43, 32'h0000_00AB, d, w, to);
    n_checks++;
    if (w != 0 || to) $display("FAIL write_hit_zero_wait: waits=%0d, want 0", w);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_load(addrs[i], sizes[i]));
      cpu_access(sizes[i], SZ_NONE, addrs[i], '0, d, w, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (w != 0 || to || d !== exp)
        $display("FAIL read_after_write[%0d]: data=%h waits=%0d, want %h waits 0", i, d, w, exp);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (d[31:24] !== 8'hAB) $display("FAIL byte3_merged: got %h want ab", d[31:24]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_writeback();
    logic [127:0] victim;
    logic [31:0] exp;
    int w;
    mem_lat = 1;
    victim = ref_get(4);
    exp_q.push_back(model_load(32'h140, SZ_WORD));
    @(negedge CLK);
    cpu.READ = SZ_WORD; cpu.WRITE = SZ_NONE; cpu.ADDR = 32'h140;
    #1;
    n_checks++;
    if (cpu.BUSYWAIT !== 1'b1) $display("FAIL dirty_miss_busy: got %b want 1", cpu.BUSYWAIT);
    else n_pass++;
    @(negedge CLK); #1;
    n_checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h000_0004 || mem_writedata !== victim)
      $display("FAIL writeback_request: wr=%b rd=%b addr=%h data=%h, want 1 0 0000004 %h",
               mem_write, mem_read, mem_addr, mem_writedata, victim);
    else n_pass++;
    w = 0;
    while (mem_write === 1'b1 && w < 100) begin @(negedge CLK); #1; w++; end
    n_checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h000_0014)
      $display("FAIL alloc_after_wb: rd=%b wr=%b addr=%h, want 1 0 0000014", mem_read, mem_write, mem_addr);
    else n_pass++;
    wait_idle(w);
    exp = exp_q.pop_front();
    n_checks++;
    if (cpu.BUSYWAIT !== 1'b0 || cpu.DATA_OUT !== exp)
      $display("FAIL hit_after_wb: busy=%b data=%h, want 0 %h", cpu.BUSYWAIT, cpu.DATA_OUT, exp);
    else n_pass++;
    n_checks++;
    if (mem_get(4) !== victim) $display("FAIL memory_got_victim: got %h want %h", mem_get(4), victim);
    else n_pass++;
  endtask

  task automatic test_alloc_stall();
    logic [31:0] exp;
    int w;
    mem_lat = 5;
    exp_q.push_back(model_load(32'h80, SZ_WORD));
    @(negedge CLK);
    cpu.READ = SZ_WORD; cpu.WRITE = SZ_NONE; cpu.ADDR = 32'h80;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      n_checks++;
      if (mem_read !== 1'b1 || cpu.BUSYWAIT !== 1'b1 || mem_addr !== 28'h000_0008 || mem_busywait !== 1'b1)
        $display("FAIL stall_cycle[%0d]: rd=%b busy=%b addr=%h membusy=%b, want 1 1 0000008 1",
                 k, mem_read, cpu.BUSYWAIT, mem_addr, mem_busywait);
      else n_pass++;
    end
    wait_idle(w);
    exp = exp_q.pop_front();
    n_checks++;
    if (w != 3 || cpu.DATA_OUT !== exp)
      $display("FAIL stall_completion: extra_cycles=%0d data=%h, want 3 %h", w, cpu.DATA_OUT, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid_alloc();
    logic [31:0] d, exp;
    int w;
    bit to;
    mem_lat = 5;
    @(negedge CLK);
    cpu.READ = SZ_WORD; cpu.WRITE = SZ_NONE; cpu.ADDR = 32'hA0;
    @(negedge CLK); #1;
    n_checks++;
    if (mem_read !== 1'b1) $display("FAIL pre_reset_alloc: mem_read=%b want 1", mem_read);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b0; cpu.READ = SZ_NONE;
    @(negedge CLK); #1;
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || cpu.BUSYWAIT !== 1'b0)
      $display("FAIL reset_abandons: rd=%b wr=%b busy=%b, want 0 0 0", mem_read, mem_write, cpu.BUSYWAIT);
    else n_pass++;
    RESET = 1'b1;
    ref_blk.delete();
    mem_lat = 1;
    exp_q.push_back(model_load(32'hA0, SZ_WORD));
    cpu_access(SZ_WORD, SZ_NONE, 32'hA0, '0, d, w, to);
    exp = exp_q.pop_front();
    n_checks++;
    if (w == 0 || to || d !== exp) $display("FAIL reread_misses: waits=%0d data=%h, want >0 %h", w, d, exp);
    else n_pass++;
    exp_q.push_back(model_load(32'h140, SZ_WORD));
    cpu_access(SZ_WORD, SZ_NONE, 32'h140, '0, d, w, to);
    exp = exp_q.pop_front();
    n_checks++;
    if (w == 0 || to || d !== exp) $display("FAIL valid_cleared: waits=%0d data=%h, want >0 %h", w, d, exp);
    else n_pass++;
  endtask

  task automatic test_read_write_both();
    logic [31:0] d, exp;
    int w;
    bit to;
    mem_lat = 0;
    model_store(32'h41, SZ_WORD, 32'h1234_5678);
    cpu_access(SZ_HALF, SZ_WORD, 32'h41, 32'h1234_5678, d, w, to);
    n_checks++;
    if (to) $display("FAIL both_completes: timed out after %0d waits", w);
    else n_pass++;
    exp_q.push_back(model_load(32'h41, SZ_HALF));
    cpu_access(SZ_HALF, SZ_NONE, 32'h41, '0, d, w, to);
    exp = exp_q.pop_front();
    n_checks++;
    if (w != 0 || d !== exp || d !== 32'h0000_5678)
      $display("FAIL half_bytes01: data=%h waits=%0d, want %h waits 0", d, w, exp);
    else n_pass++;
    exp_q.push_back(model_load(32'h40, SZ_WORD));
    cpu_access(SZ_WORD, SZ_NONE, 32'h40, '0, d, w, to);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp) $display("FAIL write_precedence: data=%h want %h", d, exp);
    else n_pass++;
    cpu_access(SZ_WORD, SZ_NONE, 32'h140, '0, d, w, to);
    n_checks++;
    if (to || mem_get(4)[31:0] !== 32'h1234_5678)
      $display("FAIL both_marks_dirty: memory word=%h want 12345678", mem_get(4)[31:0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, exp, a, dat;
    logic [1:0] sz, rsz;
    int op, blk, w;
    bit to;
    for (int i = 0; i < 48; i++) begin
      op  = int'($urandom_range(0, 2));
      sz  = 2'($urandom_range(1, 3));
      rsz = 2'($urandom_range(1, 3));
      blk = int'($urandom_range(0, 23));
      a   = (32'(blk) << 4) | 32'($urandom_range(0, 15));
      dat = $urandom();
      mem_lat = int'($urandom_range(0, 3));
      if (op == 0) begin
        exp_q.push_back(model_load(a, sz));
        cpu_access(sz, SZ_NONE, a, dat, d, w, to);
        exp = exp_q.pop_front();
        n_checks++;
        if (to || d !== exp) $display("FAIL b2b_load[%0d]: addr=%h size=%0d data=%h, want %h", i, a, sz, d, exp);
        else n_pass++;
      end else begin
        model_store(a, sz, dat);
        cpu_access((op == 2) ? rsz : SZ_NONE, sz, a, dat, d, w, to);
        n_checks++;
        if (to) $display("FAIL b2b_store[%0d]: addr=%h timed out", i, a);
        else n_pass++;
      end
    end
    for (int b = 0; b < 24; b++) begin
      a = 32'(b) << 4;
      exp_q.push_back(model_load(a | 32'h8, SZ_WORD));
      cpu_access(SZ_WORD, SZ_NONE, a | 32'h8, '0, d, w, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || d !== exp) $display("FAIL sweep[%0d]: data=%h, want %h", b, d, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_writeback();
    test_alloc_stall();
    test_reset_mid_alloc();
    test_read_write_both();
    test_back_to_back();
    n_checks++;
    if (overlap_seen !== 1'b0) $display("FAIL mem_rw_exclusive: read and write seen together");
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
